// File: rtl/stream_concat_packer_if.sv
// Valid/ready bundle between narrow word producers and the wide packed-word consumer.
// master drives the input stream and out_ready; slave is the packer.
interface stream_concat_packer_if #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
);
  localparam int OUT_W = WIDTH * COUNT;
  localparam int BW    = $clog2(COUNT + 1);

  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [BW-1:0]    out_beats;
  logic             err;

  modport master (
    output mode, in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_beats, err
  );

  modport slave (
    input  mode, in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_beats, err
  );
endinterface

// File: rtl/stream_concat_packer.sv
// Collects WIDTH-bit words and emits one COUNT*WIDTH-bit word by packing (first word in
// the MSB slot), replicating a single word, or replicating a word pair.
//
// state     | meaning
// S_IDLE    | no words collected; next beat starts a frame and latches its mode
// S_COLLECT | 0 < cnt < NEED words held in acc_q, waiting for the final beat or a flush
module stream_concat_packer #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  stream_concat_packer_if.slave  bus
);
  localparam int OUT_W = WIDTH * COUNT;
  localparam int CW    = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    MODE_PACK = 2'd0,
    MODE_REP  = 2'd1,
    MODE_PAIR = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_beats_q, out_beats_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  mode_e            cur_mode;
  logic [CW-1:0]    need;
  logic [OUT_W-1:0] acc_wr;
  logic [WIDTH-1:0] w0;
  logic             last_beat;
  logic             out_stall;
  logic             flush_eff;
  logic             in_ready;
  logic             accept;

  // Mode is taken live from the port only on the first beat; reserved mode behaves as PACK.
  always_comb begin
    cur_mode = mode_q;
    if (state_q == S_IDLE) begin
      cur_mode = (bus.mode == MODE_RSVD) ? MODE_PACK : mode_e'(bus.mode);
    end
    need = CW'(COUNT);
    case (cur_mode)
      MODE_REP:  need = CW'(1);
      MODE_PAIR: need = CW'(2);
      default:   need = CW'(COUNT);
    endcase
  end

  // Frame accumulator with the current beat written into slot cnt; a new frame starts from zero
  // so unused slots are already zero-filled when a flush closes the frame early.
  always_comb begin
    acc_wr = (state_q == S_IDLE) ? '0 : acc_q;
    for (int i = 0; i < COUNT; i++) begin
      if (cnt_q == CW'(i)) begin
        acc_wr[(COUNT-1-i)*WIDTH +: WIDTH] = bus.in_data;
      end
    end
  end

  assign w0        = acc_q[OUT_W-1 -: WIDTH];
  assign last_beat = (cnt_q == need - CW'(1));
  assign out_stall = out_valid_q && !bus.out_ready;
  assign flush_eff = bus.flush && (state_q == S_COLLECT) && (cur_mode == MODE_PACK);
  assign in_ready  = !((last_beat || flush_eff) && out_stall);
  assign accept    = bus.in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q == S_IDLE) begin
        mode_d = cur_mode;
        if (bus.mode == MODE_RSVD) begin
          err_d = 1'b1;
        end
      end
      if (last_beat) begin
        out_valid_d = 1'b1;
        out_beats_d = need;
        cnt_d       = '0;
        state_d     = S_IDLE;
        case (cur_mode)
          MODE_REP:  out_data_d = {COUNT{bus.in_data}};
          MODE_PAIR: out_data_d = {(COUNT/2){w0, bus.in_data}};
          default:   out_data_d = acc_wr;
        endcase
      end else if (flush_eff) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_wr;
        out_beats_d = cnt_q + CW'(1);
        cnt_d       = '0;
        state_d     = S_IDLE;
      end else begin
        acc_d   = acc_wr;
        cnt_d   = cnt_q + CW'(1);
        state_d = S_COLLECT;
      end
    end else if (flush_eff && !out_stall) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_q;
      out_beats_d = cnt_q;
      cnt_d       = '0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_PACK;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_stream_concat_packer.sv
// Directed bench for stream_concat_packer (WIDTH=8, COUNT=4): expected words are queued by the
// stimulus and popped by a negedge monitor on every output handshake.
module tb_stream_concat_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stream_concat_packer_if #(.WIDTH(8), .COUNT(4)) bus ();

  stream_concat_packer #(.WIDTH(8), .COUNT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data %h beats %0d, expected none", bus.out_data, bus.out_beats);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_data !== e.d || bus.out_beats !== e.b) begin
          errors++;
          $display("FAIL out_word: got data %h beats %0d expected data %h beats %0d",
                   bus.out_data, bus.out_beats, e.d, e.b);
        end
      end
    end
  end

  // All drive changes happen 1 time unit after a posedge; every task returns at that point.
  task automatic beat(input logic [7:0] d, input logic [1:0] m);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.mode     = m;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL beat_timeout: in_ready stayed 0 for data %h, expected 1", d);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic stop();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] b);
    exp_t e;
    e.d = d;
    e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.mode      = 2'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data, 32'd0);
    chk("rst_out_beats", 32'(bus.out_beats), 32'd0);
    chk("rst_err",       32'(bus.err), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    cycle();

    // PACK back-to-back with latency check
    push(32'hAA550FF0, 3'd4);
    beat(8'hAA, 2'd0);
    beat(8'h55, 2'd0);
    beat(8'h0F, 2'd0);
    chk("pack_not_early", 32'(bus.out_valid), 32'd0);
    beat(8'hF0, 2'd0);
    stop();
    chk("pack_latency", 32'(bus.out_valid), 32'd1);
    drain();

    // REP and PAIR_REP
    push(32'hAAAAAAAA, 3'd1);
    beat(8'hAA, 2'd1);
    stop();
    push(32'hAA55AA55, 3'd2);
    beat(8'hAA, 2'd2);
    beat(8'h55, 2'd2);
    stop();
    drain();

    // Backpressure: one word held, three PACK beats still accepted, fourth stalls
    bus.out_ready = 1'b0;
    push(32'h77777777, 3'd1);
    beat(8'h77, 2'd1);
    beat(8'h11, 2'd0);
    beat(8'h22, 2'd0);
    beat(8'h33, 2'd0);
    push(32'h11223344, 3'd4);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_hold_data", bus.out_data, 32'h77777777);
    end
    cycle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_in_ready", 32'(bus.in_ready), 32'd1);
    cycle();
    stop();
    chk("no_bubble_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Flush after two beats, then flush in IDLE
    push(32'hAA550000, 3'd2);
    beat(8'hAA, 2'd0);
    beat(8'h55, 2'd0);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    cycle();
    stop();
    drain();
    bus.flush = 1'b1;
    cycle();
    stop();
    repeat (3) cycle();
    chk("idle_flush_no_out", 32'(bus.out_valid), 32'd0);

    // Flush together with a beat: the beat is included first
    push(32'hA1A20000, 3'd2);
    beat(8'hA1, 2'd0);
    bus.flush = 1'b1;
    beat(8'hA2, 2'd0);
    stop();
    drain();

    // Mode change mid-frame is ignored
    push(32'hAABBCCDD, 3'd4);
    beat(8'hAA, 2'd0);
    beat(8'hBB, 2'd1);
    beat(8'hCC, 2'd1);
    beat(8'hDD, 2'd1);
    stop();
    drain();

    // Reset mid-frame discards collected words
    beat(8'h99, 2'd0);
    beat(8'h88, 2'd0);
    stop();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_beats", 32'(bus.out_beats), 32'd0);
    cycle();
    push(32'h01020304, 3'd4);
    beat(8'h01, 2'd0);
    beat(8'h02, 2'd0);
    beat(8'h03, 2'd0);
    beat(8'h04, 2'd0);
    stop();
    drain();

    // Reserved mode: handled as PACK, sets sticky err
    chk("err_before_rsvd", 32'(bus.err), 32'd0);
    push(32'h10203040, 3'd4);
    beat(8'h10, 2'd3);
    beat(8'h20, 2'd3);
    beat(8'h30, 2'd3);
    beat(8'h40, 2'd3);
    stop();
    drain();
    chk("err_sticky", 32'(bus.err), 32'd1);
    push(32'h5A5A5A5A, 3'd1);
    beat(8'h5A, 2'd1);
    stop();
    drain();
    chk("err_still_set", 32'(bus.err), 32'd1);

    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
